// File: rtl/rr_mux_pkg.sv
// Shared constants, buffer state type and clog2 helper for the round-robin stream mux.
// Optional feature macro: RRMUX_COUNT_EN (adds the xfer_count output).
package rr_mux_pkg;

    localparam int RRMUX_DEF_WIDTH  = 32;
    localparam int RRMUX_DEF_NUM_IN = 4;
    localparam int RRMUX_CNT_W      = 16;

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_t;

    function automatic int rr_clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr+1, wrapping.
// Optional feature macro RRMUX_COUNT_EN does not affect this block.
module rr_arbiter
    import rr_mux_pkg::*;
#(
    parameter int  NUM_IN = RRMUX_DEF_NUM_IN,
    localparam int SEL_W  = rr_clog2(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [NUM_IN-1:0] gnt_onehot,
    output logic [SEL_W-1:0]  gnt_idx,
    output logic              any_gnt
);

    logic [SEL_W-1:0]  cand_idx [NUM_IN];
    logic [NUM_IN-1:0] cand_req;

    // Candidate gi is the channel gi+1 places after the last winner.
    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_cand
        assign cand_idx[gi] = SEL_W'((int'(ptr) + gi + 1) % NUM_IN);
        assign cand_req[gi] = req[cand_idx[gi]];
    end

    always_comb begin
        gnt_idx = '0;
        any_gnt = 1'b0;
        for (int i = NUM_IN - 1; i >= 0; i--) begin
            if (cand_req[i]) begin
                gnt_idx = cand_idx[i];
                any_gnt = 1'b1;
            end
        end
        gnt_onehot = any_gnt ? (NUM_IN'(1) << gnt_idx) : '0;
    end

endmodule

// File: rtl/rr_arb_mux.sv
// Round-robin N:1 valid/ready mux with a single-entry registered output buffer.
// Define RRMUX_COUNT_EN to add a saturating output-handshake counter (xfer_count).
module rr_arb_mux
    import rr_mux_pkg::*;
#(
    parameter int  WIDTH  = RRMUX_DEF_WIDTH,
    parameter int  NUM_IN = RRMUX_DEF_NUM_IN,
    localparam int SEL_W  = rr_clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN-1:0]       in_valid,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    output logic [NUM_IN-1:0]       in_ready,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    input  logic                    out_ready
`ifdef RRMUX_COUNT_EN
    ,
    output logic [RRMUX_CNT_W-1:0]  xfer_count
`endif
);

    buf_state_t       state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

    logic [WIDTH-1:0]  in_word [NUM_IN];
    logic [NUM_IN-1:0] gnt_onehot;
    logic [SEL_W-1:0]  gnt_idx;
    logic              any_gnt;
    logic              can_load;
    logic              load;

    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_unpack
        assign in_word[gi] = in_data[gi*WIDTH +: WIDTH];
    end

    rr_arbiter #(.NUM_IN(NUM_IN)) u_arb (
        .req        (in_valid),
        .ptr        (rr_ptr_q),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .any_gnt    (any_gnt)
    );

    // No producer may see a grant while the block is held in reset.
    assign can_load = (state_q == BUF_EMPTY) || out_ready;
    assign load     = any_gnt && can_load && rst_n;
    assign in_ready = load ? gnt_onehot : '0;

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        sel_d    = sel_q;
        rr_ptr_d = rr_ptr_q;
        if (load) begin
            state_d  = BUF_FULL;
            data_d   = in_word[gnt_idx];
            sel_d    = gnt_idx;
            rr_ptr_d = gnt_idx;
        end else if (out_ready) begin
            state_d  = BUF_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= BUF_EMPTY;
            data_q   <= '0;
            sel_q    <= '0;
            rr_ptr_q <= SEL_W'(NUM_IN - 1);
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            sel_q    <= sel_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign out_valid = (state_q == BUF_FULL);
    assign out_data  = data_q;
    assign out_sel   = sel_q;

`ifdef RRMUX_COUNT_EN
    logic [RRMUX_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (out_valid && out_ready && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign xfer_count = cnt_q;
`endif

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed, table-driven bench for rr_arb_mux with hand-written reset and counter sequences.
// Counter checks are compiled in only when RRMUX_COUNT_EN is defined.
module tb_rr_arb_mux;

    localparam int WIDTH  = 32;
    localparam int NUM_IN = 4;

    logic                    clk;
    logic                    rst_n;
    logic [NUM_IN-1:0]       in_valid;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [NUM_IN-1:0]       in_ready;
    logic                    out_valid;
    logic [WIDTH-1:0]        out_data;
    logic [1:0]              out_sel;
    logic                    out_ready;
`ifdef RRMUX_COUNT_EN
    logic [15:0]             xfer_count;
`endif

    rr_arb_mux #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_sel    (out_sel),
        .out_ready  (out_ready)
`ifdef RRMUX_COUNT_EN
        ,
        .xfer_count (xfer_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  in_valid;
        logic        out_ready;
        logic [3:0]  exp_ready;
        logic        exp_valid;
        logic [1:0]  exp_sel;
        logic [31:0] exp_data;
    } vec_t;

    localparam int NVEC = 23;
    vec_t vecs [NVEC];

    int cmp_count;
    int err_count;

    function automatic vec_t mk(input logic [3:0] iv, input logic ordy, input logic [3:0] erdy,
                                input logic ev, input logic [1:0] es, input logic [31:0] ed);
        vec_t v;
        v.in_valid  = iv;
        v.out_ready = ordy;
        v.exp_ready = erdy;
        v.exp_valid = ev;
        v.exp_sel   = es;
        v.exp_data  = ed;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_count++;
        if (act !== exp) begin
            err_count++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    initial begin
        cmp_count = 0;
        err_count = 0;
        in_data   = {32'd3, 32'd56, 32'd151, 32'd0};

        // round-robin over all four channels
        vecs[0]  = mk(4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 32'd0);
        vecs[1]  = mk(4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 32'd151);
        vecs[2]  = mk(4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 32'd56);
        vecs[3]  = mk(4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 32'd3);
        vecs[4]  = mk(4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 32'd0);
        // backpressure for five cycles, then release
        vecs[5]  = mk(4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 32'd0);
        vecs[6]  = mk(4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 32'd0);
        vecs[7]  = mk(4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 32'd0);
        vecs[8]  = mk(4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 32'd0);
        vecs[9]  = mk(4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 32'd0);
        vecs[10] = mk(4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 32'd151);
        // sparse: channels 1 and 3 only
        vecs[11] = mk(4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3, 32'd3);
        vecs[12] = mk(4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 32'd151);
        vecs[13] = mk(4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3, 32'd3);
        vecs[14] = mk(4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 32'd151);
        // drain with no requests; data and sel hold
        vecs[15] = mk(4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1, 32'd151);
        vecs[16] = mk(4'b0000, 1'b0, 4'b0000, 1'b0, 2'd1, 32'd151);
        // empty buffer accepts even with out_ready low; lone channel re-granted
        vecs[17] = mk(4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, 32'd56);
        vecs[18] = mk(4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 32'd56);
        vecs[19] = mk(4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 32'd56);
        vecs[20] = mk(4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 32'd0);
        vecs[21] = mk(4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3, 32'd3);
        vecs[22] = mk(4'b1001, 1'b1, 4'b0001, 1'b1, 2'd0, 32'd0);

        // reset held with every channel requesting
        rst_n     = 1'b0;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  out_data,       32'd0);
        chk("rst_out_sel",   32'(out_sel),   32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        $display("reset: out_valid=%0d out_data=%0d in_ready=%b", out_valid, out_data, in_ready);
        @(negedge clk);
        in_valid = 4'b0000;
        rst_n    = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            in_valid  = vecs[i].in_valid;
            out_ready = vecs[i].out_ready;
            #1;
            chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].exp_ready));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
            chk($sformatf("v%0d_out_sel", i),   32'(out_sel),   32'(vecs[i].exp_sel));
            chk($sformatf("v%0d_out_data", i),  out_data,       vecs[i].exp_data);
            $display("vec %0d: in_valid=%b out_ready=%0d -> out_valid=%0d out_sel=%0d out_data=%0d",
                     i, vecs[i].in_valid, vecs[i].out_ready, out_valid, out_sel, out_data);
        end

        // asynchronous reset between edges while the buffer is full
        out_ready = 1'b0;
        in_valid  = 4'b1111;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out_data",  out_data,       32'd0);
        chk("mid_rst_out_sel",   32'(out_sel),   32'd0);
        chk("mid_rst_in_ready",  32'(in_ready),  32'd0);
        $display("mid reset: out_valid=%0d in_ready=%b", out_valid, in_ready);
        @(posedge clk);
        @(negedge clk);
        in_valid = 4'b0000;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_no_emit", 32'(out_valid), 32'd0);
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'b0001);
        @(posedge clk);
        #1;
        chk("post_rst_out_valid", 32'(out_valid), 32'd1);
        chk("post_rst_out_sel",   32'(out_sel),   32'd0);
        $display("post reset grant: out_valid=%0d out_sel=%0d", out_valid, out_sel);

`ifdef RRMUX_COUNT_EN
        @(negedge clk);
        rst_n     = 1'b0;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        #1;
        chk("cnt_reset", 32'(xfer_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        // first edge only loads the buffer; the next ten each complete a handshake
        repeat (11) @(posedge clk);
        #1;
        chk("cnt_ten", 32'(xfer_count), 32'd10);
        $display("count after 10 handshakes: %0d", xfer_count);
        repeat (65524) @(posedge clk);
        #1;
        chk("cnt_fffe", 32'(xfer_count), 32'hFFFE);
        @(posedge clk);
        #1;
        chk("cnt_ffff", 32'(xfer_count), 32'hFFFF);
        @(posedge clk);
        #1;
        chk("cnt_saturate", 32'(xfer_count), 32'hFFFF);
        $display("count saturated: %0h", xfer_count);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
        $finish;
    end

endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
Parametrised successor to the combinational mux2/mux4 blocks. It selects one of NUM_IN valid/ready input streams by round-robin arbitration and registers the chosen word into a single-entry output buffer. The output side also uses a valid/ready handshake. It sits between multiple producers (e.g. memory/writeback requestors) and a single shared consumer port in the CPU datapath.

Parameters:
- WIDTH, 32, data bits per channel.
- NUM_IN, 4, number of input channels; legal range 2..16.
- SEL_W, derived localparam = clog2(NUM_IN), width of the channel index.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, NUM_IN, per-channel request; bit i belongs to channel i.
- in_data, input, NUM_IN*WIDTH, flattened data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready, output, NUM_IN, per-channel accept; combinational.
- out_valid, output, 1, output buffer holds a word.
- out_data, output, WIDTH, registered selected word.
- out_sel, output, SEL_W, index of the channel that supplied out_data.
- out_ready, input, 1, consumer accepts the word.

Behaviour:
- Reset, asynchronous on rst_n low: out_valid=0, out_data=0, out_sel=0, rr_ptr=NUM_IN-1, so channel 0 has first priority.
- Buffer FSM, two states:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
- can_load = !out_valid | out_ready.
- Arbitration, combinational: search channels starting at rr_ptr+1 (mod NUM_IN) upward with wrap-around. The first channel with in_valid=1 is granted.
  - in_ready[g] = can_load.
  - All other in_ready bits = 0.
  - No valid inputs: in_ready = 0.
- Transfer in: in_valid[g] & in_ready[g] at a clock edge. Then out_data <= in_data[g], out_sel <= g, out_valid <= 1, rr_ptr <= g.
- Transfer out: out_valid & out_ready at an edge with no new grant. Then out_valid <= 0. out_data and out_sel hold their last values.
- Simultaneous drain and load in the same cycle: the buffer stays FULL with the new word, giving full throughput of one word per cycle.
- Latency: one cycle from input handshake to out_valid.
- Backpressure: while out_valid=1 and out_ready=0, out_data and out_sel are stable and in_ready=0.
- rr_ptr updates only on a successful grant. A single active channel is re-granted every cycle.
- Inputs must hold in_data stable while in_valid=1 and not accepted. The block does not check this.
- Reset mid-transfer: the buffered word is discarded and nothing is emitted after reset is released until a new grant.

Optional Feature:
- Macro: RRMUX_COUNT_EN.
- Defined: adds output port xfer_count[15:0].
  - Increments on every output handshake (out_valid & out_ready).
  - Saturates at 16'hFFFF.
  - Reset to 0.
- Undefined: the port and the counter are absent. All other behaviour is identical.

Decomposition:
- Shared package rr_mux_pkg (include file) holds:
  - the clog2 function,
  - the default WIDTH/NUM_IN constants,
  - the counter width constant RRMUX_CNT_W=16.
- One sub-module, rr_arbiter:
  - parameter NUM_IN; inputs req[NUM_IN], ptr[SEL_W]; outputs gnt_onehot[NUM_IN], gnt_idx[SEL_W], any_gnt.
  - Purely combinational.
- The pointer and the data register live in rr_arb_mux.

Test Plan:
1. Reset: hold rst_n=0 with in_valid=4'b1111 -> out_valid=0, out_data=0, in_ready=0 while in reset; first grant after release is channel 0.
2. Round-robin: data {3,56,151,0} on channels 3..0, all valid, out_ready=1 -> out_sel sequence 0,1,2,3,0 with out_data 0,151,56,3,0, one word per cycle.
3. Backpressure: out_ready=0 after the first load -> out_data=0 and out_sel=0 stable for 5 cycles, in_ready=0; release -> next word 151 from channel 1.
4. Sparse requests: only channels 1 and 3 valid (151, 3) -> alternates 1,3,1,3; channels 0 and 2 never granted.
5. Mid-operation reset: assert rst_n=0 asynchronously between edges while FULL -> out_valid drops immediately; after release, channel 0 has priority again.
6. RRMUX_COUNT_EN build: 10 output handshakes -> xfer_count=10; force the count to 16'hFFFF -> the next handshake leaves it at 16'hFFFF.
